// File: rtl/apb_mem_bridge.sv
// apb_mem_bridge: APB3 completer that turns each bus transfer into one
// single-word access on a local ROM/RAM port (clocked or combinational).
// Decodes the address, raises errors for bad accesses, inserts the wait
// states needed to line up with the memory read latency, and registers
// every output.
module apb_mem_bridge #(
  parameter int ADDRW    = 32,
  parameter int ATW      = 5,
  parameter int DEPTH    = 32,
  parameter int DATAW    = 32,
  parameter int RDLAT    = 1,
  parameter int READONLY = 0
) (
  input  logic             mem_clk,
  input  logic             mem_rst_n,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [ADDRW-1:0] paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pready,
  output logic             pslverr,
  output logic [ATW-1:0]   mem_address,
  output logic             mem_op,
  output logic             mem_cs,
  output logic [DATAW-1:0] mem_wdata,
  input  logic [DATAW-1:0] mem_rdata
);

  // Parameter sanity: bad combinations stop elaboration.
  if (ATW != $clog2(DEPTH)) begin : g_chkAtw
    $error("apb_mem_bridge: ATW must equal clog2(DEPTH)");
  end
  if (DATAW > 32) begin : g_chkDataw
    $error("apb_mem_bridge: DATAW must be <= 32");
  end
  if (RDLAT > 3 || RDLAT < 0) begin : g_chkRdlat
    $error("apb_mem_bridge: RDLAT must be in 0..3");
  end

  typedef enum logic [2:0] {
    IDLE,
    MEM,
    WAIT,
    RESP,
    ERR
  } state_t;

  // Word count compared against the word part of the byte address.
  localparam logic [ADDRW-3:0] DEPTH_W    = (ADDRW-2)'(DEPTH);
  // WAIT runs RDLAT-1 extra cycles after MEM before capturing read data.
  localparam int               CNT_INIT_I = (RDLAT > 0) ? RDLAT - 1 : 0;
  localparam logic [1:0]       CNT_INIT   = CNT_INIT_I[1:0];

  state_t           r_state;
  state_t           w_nextState;
  logic [1:0]       r_cnt;
  logic [1:0]       w_nextCnt;
  logic [31:0]      r_prdata;
  logic [31:0]      w_nextPrdata;
  logic             r_pready;
  logic             w_nextPready;
  logic             r_pslverr;
  logic             w_nextPslverr;
  logic [ATW-1:0]   r_memAddress;
  logic [ATW-1:0]   w_nextMemAddress;
  logic             r_memOp;
  logic             w_nextMemOp;
  logic             r_memCs;
  logic             w_nextMemCs;
  logic [DATAW-1:0] r_memWdata;
  logic [DATAW-1:0] w_nextMemWdata;

  logic             w_setup;
  logic             w_err;
  logic [31:0]      w_rdataExt;

  assign w_setup    = psel & ~penable;
  assign w_err      = (paddr[1:0] != 2'b00)
                    | (paddr[ADDRW-1:2] >= DEPTH_W)
                    | (pwrite & (READONLY != 0));
  assign w_rdataExt = 32'(mem_rdata);

  assign prdata      = r_prdata;
  assign pready      = r_pready;
  assign pslverr     = r_pslverr;
  assign mem_address = r_memAddress;
  assign mem_op      = r_memOp;
  assign mem_cs      = r_memCs;
  assign mem_wdata   = r_memWdata;

  // State register of the transfer FSM.
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus next value of every registered output; the responses
  // are decided one cycle early so that they appear straight from flops.
  always_comb begin
    w_nextState      = r_state;
    w_nextCnt        = r_cnt;
    w_nextPrdata     = '0;
    w_nextPready     = 1'b0;
    w_nextPslverr    = 1'b0;
    w_nextMemCs      = 1'b0;
    w_nextMemAddress = r_memAddress;
    w_nextMemOp      = r_memOp;
    w_nextMemWdata   = r_memWdata;
    case (r_state)
      IDLE: begin
        w_nextMemAddress = '0;
        w_nextMemOp      = 1'b0;
        w_nextMemWdata   = '0;
        w_nextCnt        = '0;
        if (w_setup) begin
          if (w_err) begin
            w_nextState   = ERR;
            w_nextPready  = 1'b1;
            w_nextPslverr = 1'b1;
          end else begin
            w_nextState      = MEM;
            w_nextMemCs      = 1'b1;
            w_nextMemAddress = paddr[ATW+1:2];
            w_nextMemOp      = pwrite;
            w_nextMemWdata   = pwdata[DATAW-1:0];
          end
        end
      end
      MEM: begin
        if (!psel) begin
          w_nextState      = IDLE;
          w_nextMemAddress = '0;
          w_nextMemOp      = 1'b0;
          w_nextMemWdata   = '0;
        end else if (r_memOp) begin
          w_nextState  = RESP;
          w_nextPready = 1'b1;
        end else if (RDLAT == 0) begin
          w_nextState  = RESP;
          w_nextPready = 1'b1;
          w_nextPrdata = w_rdataExt;
        end else begin
          w_nextState = WAIT;
          w_nextCnt   = CNT_INIT;
        end
      end
      WAIT: begin
        if (!psel) begin
          w_nextState      = IDLE;
          w_nextCnt        = '0;
          w_nextMemAddress = '0;
          w_nextMemOp      = 1'b0;
          w_nextMemWdata   = '0;
        end else if (r_cnt == 2'd0) begin
          w_nextState  = RESP;
          w_nextPready = 1'b1;
          w_nextPrdata = w_rdataExt;
        end else begin
          w_nextCnt = r_cnt - 2'd1;
        end
      end
      default: begin
        w_nextState      = IDLE;
        w_nextCnt        = '0;
        w_nextMemAddress = '0;
        w_nextMemOp      = 1'b0;
        w_nextMemWdata   = '0;
      end
    endcase
  end

  // Output and latency-counter registers, all cleared by reset.
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      r_cnt        <= '0;
      r_prdata     <= '0;
      r_pready     <= 1'b0;
      r_pslverr    <= 1'b0;
      r_memAddress <= '0;
      r_memOp      <= 1'b0;
      r_memCs      <= 1'b0;
      r_memWdata   <= '0;
    end else begin
      r_cnt        <= w_nextCnt;
      r_prdata     <= w_nextPrdata;
      r_pready     <= w_nextPready;
      r_pslverr    <= w_nextPslverr;
      r_memAddress <= w_nextMemAddress;
      r_memOp      <= w_nextMemOp;
      r_memCs      <= w_nextMemCs;
      r_memWdata   <= w_nextMemWdata;
    end
  end

endmodule

// File: doc/apb_mem_bridge.md
Name: apb_mem_bridge

Overview:
- APB3 completer that converts bus transfers into single-word accesses on the mem_* port of the local memory slaves (ROM/RAM, clocked or combinational).
- Sits between the APB interconnect and one memory instance.
- Owns address decode, read-latency alignment, wait-state insertion and error signalling.

Parameters:
- ADDRW, 32, APB address width.
- ATW, 5, memory word-address width; must equal clog2(DEPTH).
- DEPTH, 32, memory depth in words.
- DATAW, 32, memory data width; must be <= 32.
- RDLAT, 1, memory read latency in cycles after the mem_cs sample edge: 0 for a combinational memory, 1 for a clocked memory. Legal range 0..3.
- READONLY, 0, when 1 every APB write is rejected with pslverr.

Ports:
- mem_clk  in  1  single clock, rising edge
- mem_rst_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDRW  byte address
- pwdata  in  32  write data
- prdata  out  32  read data
- pready  out  1  transfer complete
- pslverr  out  1  transfer error, valid only with pready
- mem_address  out  ATW  word address to memory
- mem_op  out  1  1 = write, 0 = read
- mem_cs  out  1  memory chip select, one-cycle pulse
- mem_wdata  out  DATAW  pwdata[DATAW-1:0]
- mem_rdata  in  DATAW  memory read data

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; latency counter 0.
- All outputs are registered.
- FSM states: IDLE, MEM, WAIT, RESP, ERR.
- IDLE:
  - A setup phase is psel=1 and penable=0.
  - On a setup phase with an error condition: go to ERR.
  - On a setup phase with no error: register mem_address = paddr[ATW+1:2], mem_op = pwrite, mem_wdata = pwdata[DATAW-1:0], set mem_cs = 1, go to MEM.
- Error conditions:
  - paddr[1:0] != 0;
  - paddr[ADDRW-1:2] >= DEPTH;
  - pwrite=1 and READONLY=1.
- ERR: pready=1, pslverr=1, prdata=0, mem_cs stays 0; next state IDLE. A rejected transfer completes in the cycle after setup (zero wait states) and never touches memory.
- MEM: mem_cs=1 for exactly this cycle.
  - Write: go to RESP.
  - Read with RDLAT=0: capture mem_rdata at the end of MEM, go to RESP.
  - Read with RDLAT>0: load counter = RDLAT-1, go to WAIT.
- WAIT: mem_cs=0; decrement counter; at counter==0 capture mem_rdata and go to RESP.
- RESP: pready=1, pslverr=0.
  - Read: prdata = captured mem_rdata zero-extended to 32 bits.
  - Write: prdata = 0.
  - Next state IDLE.
  - mem_address, mem_op and mem_wdata hold until RESP completes, then clear to 0.
- Completion latency, with setup in cycle 0:
  - write: pready in cycle 2;
  - read: pready in cycle 2+RDLAT;
  - error: pready in cycle 1.
- pready is a single-cycle pulse. prdata and pslverr are 0 whenever pready=0.
- Back-to-back transfers: a setup phase is accepted in the cycle after RESP/ERR. No pipelining; one transfer is outstanding at most.
- Protocol violation (psel drops in MEM/WAIT/RESP/ERR): go to IDLE next cycle, no pready, clear mem_* outputs. A write already strobed in MEM is not undone.
- penable=1 seen in IDLE without a prior setup phase is ignored.
- Reset mid-transfer: all outputs go to 0 immediately; no pready is produced for the aborted transfer.
- Elaboration checks: ATW==$clog2(DEPTH), DATAW<=32, RDLAT<=3; $error on violation.

Test Plan:
- RDLAT=1, memory preloaded with word 5 = 0xDEADBEEF: read paddr=0x14 -> mem_cs pulse in cycle 1 with mem_address=5 and mem_op=0; pready=1 with prdata=0xDEADBEEF in cycle 3; pslverr=0.
- Write paddr=0x7C, pwdata=0xA5A5_0001 -> mem_cs=1, mem_op=1, mem_address=31, mem_wdata=0xA5A50001 in cycle 1; pready in cycle 2; a following read of 0x7C returns 0xA5A50001.
- Error cases: paddr=0x80 (out of range), paddr=0x06 (misaligned), and a write with READONLY=1 -> each gives pready=1 and pslverr=1 in cycle 1, prdata=0, mem_cs never asserted.
- RDLAT=0 against a combinational memory: read word 0 = 0x1234 -> pready in cycle 2, prdata=0x00001234. Then an immediate back-to-back read of word 1 -> setup accepted in the cycle after RESP.
- Assert mem_rst_n low during WAIT of a read -> all outputs 0 in the same cycle, no pready after release; the next read completes normally.
- Drop psel during WAIT -> no pready, FSM returns to IDLE, mem_address=0 on the next cycle.
